// File: rtl/r4_lmc_core_if.sv
// rtl/r4_lmc_core_if.sv - front-panel bus between the panel controls and r4_lmc_core
// The panel drives buttons, switches and data_in; the core returns its state and flags.
interface r4_lmc_core_if #(
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 4
);
  logic                  JMP;
  logic                  Z_JMP;
  logic                  PZ_JMP;
  logic                  Output_button;
  logic                  Acc_button;
  logic                  RAM_button;
  logic [1:0]            MUX_switch;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  Z_flag;
  logic                  PZ_flag;
  logic [DATA_WIDTH-1:0] data_out;
  logic [DATA_WIDTH-1:0] Acc;
  logic [ADDR_WIDTH-1:0] counter;
  logic [DATA_WIDTH-1:0] RAM_out;

  modport master (
    output JMP, Z_JMP, PZ_JMP, Output_button, Acc_button, RAM_button,
    output MUX_switch, data_in,
    input  Z_flag, PZ_flag, data_out, Acc, counter, RAM_out
  );

  modport slave (
    input  JMP, Z_JMP, PZ_JMP, Output_button, Acc_button, RAM_button,
    input  MUX_switch, data_in,
    output Z_flag, PZ_flag, data_out, Acc, counter, RAM_out
  );
endinterface

// File: rtl/r4_lmc_core.sv
// rtl/r4_lmc_core.sv - 4-bit Little-Man-style accumulator machine with 2-bit PC and 4-word RAM
// Define R4_SUB_EN to build the Acc - RAM_out path on MUX_switch=11; otherwise 11 aliases the adder.
module r4_lmc_core #(
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 4
) (
  input  logic         timer555,
  input  logic         reset,
  r4_lmc_core_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [ADDR_WIDTH-1:0] counter_q, counter_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [DATA_WIDTH-1:0] out_q, out_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [DATA_WIDTH-1:0] ram_rd;
  logic [DATA_WIDTH-1:0] sum;
  logic                  z_flag;
  logic                  pz_flag;
  logic                  jump_taken;

  assign ram_rd     = mem_q[counter_q];
  assign z_flag     = (acc_q == '0);
  assign pz_flag    = ~acc_q[DATA_WIDTH-1];
  assign sum        = acc_q + ram_rd;
  // Flags are taken from the pre-edge accumulator, so a conditional jump never sees its own load.
  assign jump_taken = bus.JMP | (bus.Z_JMP & z_flag) | (bus.PZ_JMP & pz_flag);

`ifdef R4_SUB_EN
  logic [DATA_WIDTH-1:0] diff;
  assign diff = acc_q - ram_rd;
`endif

  always_comb begin
    counter_d = counter_q + ADDR_WIDTH'(1);
    if (jump_taken) begin
      counter_d = bus.data_in[ADDR_WIDTH-1:0];
    end
  end

  always_comb begin
    acc_d = acc_q;
    if (bus.Acc_button) begin
      case (bus.MUX_switch)
        2'b00:   acc_d = bus.data_in;
        2'b01:   acc_d = ram_rd;
        2'b10:   acc_d = sum;
`ifdef R4_SUB_EN
        default: acc_d = diff;
`else
        default: acc_d = sum;
`endif
      endcase
    end
  end

  always_comb begin
    out_d = out_q;
    if (bus.Output_button) begin
      out_d = acc_q;
    end
  end

  always_ff @(posedge timer555 or posedge reset) begin
    if (reset) begin
      counter_q <= '0;
      acc_q     <= '0;
      out_q     <= '0;
    end else begin
      counter_q <= counter_d;
      acc_q     <= acc_d;
      out_q     <= out_d;
    end
  end

  // Write address and data are the pre-edge counter and accumulator, even when both change this edge.
  always_ff @(posedge timer555 or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (bus.RAM_button) begin
      mem_q[counter_q] <= acc_q;
    end
  end

  assign bus.counter  = counter_q;
  assign bus.Acc      = acc_q;
  assign bus.data_out = out_q;
  assign bus.RAM_out  = ram_rd;
  assign bus.Z_flag   = z_flag;
  assign bus.PZ_flag  = pz_flag;
endmodule

// File: tb/tb_r4_lmc_core.sv
// tb/tb_r4_lmc_core.sv - directed and random bench for r4_lmc_core against a behavioural model
// Honours R4_SUB_EN the same way as the design when computing the MUX_switch=11 result.
module tb_r4_lmc_core;
  logic clk = 1'b0;
  logic rst = 1'b0;

  r4_lmc_core_if #(.ADDR_WIDTH(2), .DATA_WIDTH(4)) bus ();

  r4_lmc_core #(.ADDR_WIDTH(2), .DATA_WIDTH(4)) dut (
    .timer555 (clk),
    .reset    (rst),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  logic [1:0] m_cnt;
  logic [3:0] m_acc;
  logic [3:0] m_out;
  logic [3:0] m_mem [4];

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0;
    m_acc = 0;
    m_out = 0;
    for (int i = 0; i < 4; i++) m_mem[i] = 0;
  endtask

  task automatic check_all(input string where);
    chk({where, ":counter"},  8'(bus.counter),  8'(m_cnt));
    chk({where, ":Acc"},      8'(bus.Acc),      8'(m_acc));
    chk({where, ":data_out"}, 8'(bus.data_out), 8'(m_out));
    chk({where, ":RAM_out"},  8'(bus.RAM_out),  8'(m_mem[m_cnt]));
    chk({where, ":Z_flag"},   8'(bus.Z_flag),   8'(m_acc == 0));
    chk({where, ":PZ_flag"},  8'(bus.PZ_flag),  8'(m_acc < 8));
  endtask

  // One rising edge of the machine, described from the panel's point of view.
  task automatic model_edge();
    logic [3:0] ram;
    logic [3:0] old_acc;
    bit         take;
    ram     = m_mem[m_cnt];
    old_acc = m_acc;
    take    = bus.JMP || (bus.Z_JMP && old_acc == 0) || (bus.PZ_JMP && old_acc < 8);
    if (bus.RAM_button) m_mem[m_cnt] = old_acc;
    if (bus.Output_button) m_out = old_acc;
    if (bus.Acc_button) begin
      if (bus.MUX_switch == 0) m_acc = bus.data_in;
      else if (bus.MUX_switch == 1) m_acc = ram;
      else if (bus.MUX_switch == 2) m_acc = old_acc + ram;
`ifdef R4_SUB_EN
      else m_acc = old_acc - ram;
`else
      else m_acc = old_acc + ram;
`endif
    end
    m_cnt = take ? bus.data_in[1:0] : m_cnt + 2'd1;
  endtask

  task automatic drive(input bit jmp, input bit zj, input bit pzj, input bit ob, input bit ab,
                       input bit rb, input logic [1:0] mux, input logic [3:0] din);
    bus.JMP = jmp; bus.Z_JMP = zj; bus.PZ_JMP = pzj;
    bus.Output_button = ob; bus.Acc_button = ab; bus.RAM_button = rb;
    bus.MUX_switch = mux; bus.data_in = din;
  endtask

  task automatic step(input string where);
    @(posedge clk);
    model_edge();
    #1;
    check_all(where);
  endtask

  task automatic async_reset(input string where);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all(where);
    chk({where, ":Z_const"},  8'(bus.Z_flag),  8'd1);
    chk({where, ":PZ_const"}, 8'(bus.PZ_flag), 8'd1);
    #1 rst = 1'b0;
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0, 2'b00, 4'd0);
    model_reset();
    #3 rst = 1'b1;
    #1;
    check_all("reset");
    #3 rst = 1'b0;

    for (int i = 0; i < 4; i++) begin
      step("run");
      chk("run_seq", 8'(bus.counter), 8'((i + 1) % 4));
    end

    drive(1, 0, 0, 0, 0, 0, 2'b00, 4'b0010); step("jmp");
    chk("jmp_to_2", 8'(bus.counter), 8'd2);
    drive(0, 0, 0, 0, 0, 0, 2'b00, 4'd0); step("after_jmp");
    chk("after_jmp_3", 8'(bus.counter), 8'd3);
    step("after_jmp2");
    chk("after_jmp_0", 8'(bus.counter), 8'd0);

    drive(0, 0, 0, 0, 1, 0, 2'b00, 4'd7); step("load7");
    drive(1, 0, 0, 0, 0, 0, 2'b00, 4'd3); step("jmp3");
    drive(0, 0, 0, 0, 0, 1, 2'b00, 4'd0); step("store7");
    drive(0, 0, 0, 0, 1, 0, 2'b00, 4'd3); step("load3");
    chk("load3_acc", 8'(bus.Acc), 8'd3);
    drive(0, 0, 0, 0, 0, 1, 2'b00, 4'd0); step("store3");
    drive(1, 0, 0, 0, 0, 0, 2'b00, 4'd1); step("jmp1");
    chk("ram_readback_3", 8'(bus.RAM_out), 8'd3);
    drive(0, 0, 0, 0, 1, 0, 2'b10, 4'd0); step("add");
    chk("add_acc_6", 8'(bus.Acc), 8'd6);
    drive(1, 0, 0, 0, 0, 0, 2'b00, 4'd3); step("jmp3b");
    chk("ram_readback_7", 8'(bus.RAM_out), 8'd7);
    drive(0, 0, 0, 0, 1, 0, 2'b11, 4'd0); step("mux11");
`ifdef R4_SUB_EN
    chk("sub_acc_15", 8'(bus.Acc), 8'd15);
`else
    chk("mux11_add_13", 8'(bus.Acc), 8'd13);
`endif
    chk("mux11_z", 8'(bus.Z_flag), 8'd0);
    chk("mux11_pz", 8'(bus.PZ_flag), 8'd0);

    drive(0, 0, 0, 0, 1, 0, 2'b00, 4'd0); step("load0");
    drive(0, 1, 0, 0, 0, 0, 2'b00, 4'd1); step("zjmp_taken");
    chk("zjmp_taken_cnt", 8'(bus.counter), 8'd1);
    drive(0, 0, 0, 0, 1, 0, 2'b00, 4'b1000); step("load8");
    drive(0, 0, 1, 0, 0, 0, 2'b00, 4'd0); step("pzjmp_not");
    chk("pzjmp_not_cnt", 8'(bus.counter), 8'd3);
    drive(0, 0, 0, 0, 1, 0, 2'b00, 4'b0101); step("load5");
    drive(0, 1, 0, 0, 0, 0, 2'b00, 4'd2); step("zjmp_not");
    chk("zjmp_not_cnt", 8'(bus.counter), 8'd1);

    drive(0, 0, 0, 1, 1, 0, 2'b00, 4'd9); step("out_acc");
    chk("out_old_acc", 8'(bus.data_out), 8'd5);
    chk("acc_new_9", 8'(bus.Acc), 8'd9);
    drive(0, 0, 0, 1, 0, 0, 2'b00, 4'd0); step("out_again");
    chk("out_9", 8'(bus.data_out), 8'd9);

    drive(1, 0, 0, 0, 1, 1, 2'b01, 4'd2); step("jmp_store");
    async_reset("mid_reset");
    drive(0, 0, 0, 0, 0, 0, 2'b00, 4'd0); step("post_reset");
    chk("post_reset_cnt", 8'(bus.counter), 8'd1);

    for (int i = 0; i < 300; i++) begin
      drive($urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 1) == 1, $urandom_range(0, 2) != 0, $urandom_range(0, 2) == 0,
            2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
      step("rand");
      if ($urandom_range(0, 39) == 0) async_reset("rand_reset");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/r4_lmc_core.md
Name: r4_lmc_core

Overview:
- Minimal 4-bit accumulator machine in the Little Man Computer style, clocked by timer555.
- Contains a 2-bit program counter that addresses a 4x4 RAM, plus a 4-bit accumulator fed through a 4-way source mux.
- Also contains an output register and zero / positive-or-zero flags with conditional jumps.
- Sits under front-panel control: buttons and switches act as per-cycle enables.

Parameters:
- ADDR_WIDTH, 2, program counter / RAM address width (RAM depth = 2**ADDR_WIDTH).
- DATA_WIDTH, 4, width of accumulator, RAM words, data_in and data_out.

Ports:
- timer555  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- JMP  input  1  unconditional jump request.
- Z_JMP  input  1  jump if Z_flag.
- PZ_JMP  input  1  jump if PZ_flag.
- Z_flag  output  1  Acc == 0.
- PZ_flag  output  1  Acc MSB == 0 (positive or zero).
- Output_button  input  1  load data_out from Acc.
- data_out  output  DATA_WIDTH  output register.
- MUX_switch  input  2  accumulator source select.
- Acc_button  input  1  accumulator load enable.
- Acc  output  DATA_WIDTH  accumulator value.
- counter  output  ADDR_WIDTH  program counter.
- RAM_button  input  1  RAM write enable.
- data_in  input  DATA_WIDTH  panel data / jump target.
- RAM_out  output  DATA_WIDTH  RAM word at address counter.

Behaviour:
- Single clock; reset is asynchronous and active-high.
- Reset values: counter=0, Acc=0, data_out=0, all RAM words=0.
- Reset asserted mid-operation clears all state immediately, independent of the clock.
- All inputs are sampled on the rising edge of timer555. Buttons are level enables; holding one for N edges acts N times.
- Counter update, priority order each edge:
  - JMP: counter <= data_in[ADDR_WIDTH-1:0].
  - else Z_JMP and Z_flag: same load.
  - else PZ_JMP and PZ_flag: same load.
  - else counter <= counter+1, wrapping 3 -> 0.
- RAM:
  - Asynchronous read: RAM_out = mem[counter].
  - RAM_button: mem[counter] <= Acc, where Acc and counter are the pre-edge values.
- Accumulator (when Acc_button=1), MUX_switch selects the new value:
  - 00: data_in.
  - 01: RAM_out.
  - 10: Acc + RAM_out, modulo 2**DATA_WIDTH.
  - 11: Acc - RAM_out, modulo 2**DATA_WIDTH.
  - Acc holds its value when Acc_button=0.
- Output: Output_button=1 -> data_out <= Acc (pre-edge value); otherwise data_out holds.
- Simultaneous events:
  - Acc_button with RAM_button: RAM stores the old Acc and Acc takes the new value.
  - Output_button with Acc_button: data_out gets the old Acc.
  - Any jump with RAM_button: the write uses the old counter.
- Flags are combinational from the current Acc. Conditional jumps use pre-edge flags.
- No carry or overflow output; arithmetic wraps silently.

Optional Feature:
- Macro: R4_SUB_EN.
- Defined: MUX_switch=11 selects Acc - RAM_out as above.
- Not defined: MUX_switch=11 behaves identically to 10 (Acc + RAM_out), and the subtractor is not built.

Test Plan:
- Reset: assert reset between edges -> counter=0, Acc=0, data_out=0, RAM_out=0, Z_flag=1, PZ_flag=1 immediately. Release -> counter runs 1,2,3,0 on successive edges.
- Jump: data_in=4'b0010, JMP=1 for one edge -> counter=2. Then JMP=0 -> counter=3, then 0.
- Load/store: MUX=00, data_in=4'b0011, Acc_button=1 for one edge -> Acc=3. Next edge RAM_button=1 at counter=k -> mem[k]=3. Jump to k -> RAM_out=3.
- Add/sub:
  - Acc=3, RAM_out=3, MUX=10, Acc_button -> Acc=6.
  - Then MUX=11 with RAM_out=7 -> Acc=15, Z_flag=0, PZ_flag=0 (with R4_SUB_EN).
  - Without R4_SUB_EN -> Acc=13.
- Conditional jumps:
  - Acc=0: Z_JMP=1, data_in=1 -> counter=1.
  - Acc=4'b1000: PZ_JMP=1 -> counter increments instead.
  - Acc=4'b0101: Z_JMP=1 -> counter increments.
- Output and simultaneity: Acc=5; Output_button and Acc_button (MUX=00, data_in=9) on the same edge -> data_out=5, Acc=9. Next Output_button edge -> data_out=9.
